// File: rtl/fir_sched_pkg.sv
// Shared types and default parameters for the FIR command scheduler.
package fir_sched_pkg;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_NUM_COEFF = 4;
    localparam int DEF_TIMEOUT   = 4;

    typedef enum logic [2:0] {
        IDLE,
        DR1,
        DR2,
        LC,
        WAIT_BUSY,
        WAIT_DONE
    } sched_state_t;

    typedef enum logic {
        OP_SAMPLE,
        OP_COEFF
    } sched_op_t;

endpackage

// File: rtl/fir_sample_buf.sv
// One-entry holding register for the sample stream. It fills on a
// valid/ready handshake and empties when the scheduler launches the sample.
module fir_sample_buf
    import fir_sched_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk_i,
    input  logic              n_rst_i,
    input  logic              wr_valid_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_ready_o,
    input  logic              pop_i,
    output logic              full_o,
    output logic [DATA_W-1:0] data_o
);

    logic              full_q, full_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Fill when empty and offered; pop only ever happens while full.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (wr_valid_i && !full_q) begin
            full_d = 1'b1;
            data_d = wr_data_i;
        end else if (pop_i) begin
            full_d = 1'b0;
        end
    end

    // Buffer state register.
    always_ff @(posedge clk_i) begin
        if (!n_rst_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign wr_ready_o = !full_q;
    assign full_o     = full_q;
    assign data_o     = data_q;

endmodule

// File: rtl/fir_cmd_scheduler.sv
// Shares the FIR core between a sample stream and a coefficient stream,
// sequences dr/lc commands, tracks modwait and reports completion.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | arbitrate; a grant loads the operand bus
// DR1       | first cycle of data-ready to the core
// DR2       | second cycle of data-ready (core re-samples dr)
// LC        | single-cycle load-coefficient to the core
// WAIT_BUSY | wait for modwait to rise, watchdog running
// WAIT_DONE | wait for modwait to fall, then report
module fir_cmd_scheduler
    import fir_sched_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_COEFF = DEF_NUM_COEFF,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic              clk_i,
    input  logic              n_rst_i,
    input  logic              sample_valid_i,
    input  logic [DATA_W-1:0] sample_in_i,
    output logic              sample_ready_o,
    input  logic              coeff_valid_i,
    input  logic [DATA_W-1:0] coeff_in_i,
    output logic              coeff_ready_o,
    output logic              core_dr_o,
    output logic              core_lc_o,
    output logic [DATA_W-1:0] core_data_o,
    input  logic              core_modwait_i,
    input  logic              core_err_i,
    output logic              result_valid_o,
    output logic              err_pulse_o,
    output logic              timeout_flag_o,
    output logic              coeff_done_o,
    output logic              coeff_busy_o
);

    localparam int CNT_W = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_COEFF - 1);
    localparam logic [WD_W-1:0]  WD_INIT  = WD_W'(TIMEOUT);

    sched_state_t      state_q, state_d;
    sched_op_t         op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              result_q, result_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              tflag_q, tflag_d;

    logic              buf_full;
    logic [DATA_W-1:0] buf_data;
    logic              buf_pop;
    logic              coeff_busy;
    logic              grant_sample;
    logic              grant_coeff;

    fir_sample_buf #(
        .DATA_W (DATA_W)
    ) u_sample_buf (
        .clk_i      (clk_i),
        .n_rst_i    (n_rst_i),
        .wr_valid_i (sample_valid_i),
        .wr_data_i  (sample_in_i),
        .wr_ready_o (sample_ready_o),
        .pop_i      (buf_pop),
        .full_o     (buf_full),
        .data_o     (buf_data)
    );

    // A reload set in progress locks out samples so the set stays contiguous.
    assign coeff_busy   = (cnt_q != '0);
    assign grant_sample = (state_q == IDLE) && buf_full && !coeff_busy;
    assign grant_coeff  = (state_q == IDLE) && coeff_valid_i && !grant_sample;
    assign buf_pop      = grant_sample;

    // Next-state, operand capture, watchdog and completion reporting.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        wdog_d   = wdog_q;
        data_d   = data_q;
        result_d = 1'b0;
        err_d    = 1'b0;
        done_d   = 1'b0;
        tflag_d  = tflag_q;
        case (state_q)
            IDLE: begin
                wdog_d = WD_INIT;
                if (grant_sample) begin
                    data_d  = buf_data;
                    op_d    = OP_SAMPLE;
                    state_d = DR1;
                end else if (grant_coeff) begin
                    data_d  = coeff_in_i;
                    op_d    = OP_COEFF;
                    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
                    state_d = LC;
                end
            end
            DR1:  state_d = DR2;
            DR2:  state_d = WAIT_BUSY;
            LC:   state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (core_modwait_i) begin
                    state_d = WAIT_DONE;
                end else if (wdog_q == WD_W'(1)) begin
                    // Coefficient count is not rolled back: the set resumes
                    // with the next coefficient.
                    state_d = IDLE;
                    err_d   = 1'b1;
                    tflag_d = 1'b1;
                end else begin
                    wdog_d = wdog_q - WD_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!core_modwait_i) begin
                    state_d = IDLE;
                    if (op_q == OP_SAMPLE) begin
                        if (core_err_i) begin
                            err_d = 1'b1;
                        end else begin
                            result_d = 1'b1;
                            tflag_d  = 1'b0;
                        end
                    end else if (cnt_q == '0) begin
                        done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any command silently.
    always_ff @(posedge clk_i) begin
        if (!n_rst_i) begin
            state_q  <= IDLE;
            op_q     <= OP_SAMPLE;
            cnt_q    <= '0;
            wdog_q   <= '0;
            data_q   <= '0;
            result_q <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            tflag_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            wdog_q   <= wdog_d;
            data_q   <= data_d;
            result_q <= result_d;
            err_q    <= err_d;
            done_q   <= done_d;
            tflag_q  <= tflag_d;
        end
    end

    assign coeff_ready_o  = grant_coeff;
    assign core_dr_o      = (state_q == DR1) || (state_q == DR2);
    assign core_lc_o      = (state_q == LC);
    assign core_data_o    = data_q;
    assign result_valid_o = result_q;
    assign err_pulse_o    = err_q;
    assign timeout_flag_o = tflag_q;
    assign coeff_done_o   = done_q;
    assign coeff_busy_o   = coeff_busy;

endmodule

// File: tb/tb_fir_cmd_scheduler.sv
// Directed bench for fir_cmd_scheduler with a simple FIR core busy model.
module tb_fir_cmd_scheduler;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_in = '0;
    logic        sample_ready;
    logic        coeff_valid = 1'b0;
    logic [15:0] coeff_in = '0;
    logic        coeff_ready;
    logic        core_dr;
    logic        core_lc;
    logic [15:0] core_data;
    logic        core_modwait = 1'b0;
    logic        core_err = 1'b0;
    logic        result_valid;
    logic        err_pulse;
    logic        timeout_flag;
    logic        coeff_done;
    logic        coeff_busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fir_cmd_scheduler #(
        .DATA_W    (16),
        .NUM_COEFF (4),
        .TIMEOUT   (4)
    ) dut (
        .clk_i          (clk),
        .n_rst_i        (n_rst),
        .sample_valid_i (sample_valid),
        .sample_in_i    (sample_in),
        .sample_ready_o (sample_ready),
        .coeff_valid_i  (coeff_valid),
        .coeff_in_i     (coeff_in),
        .coeff_ready_o  (coeff_ready),
        .core_dr_o      (core_dr),
        .core_lc_o      (core_lc),
        .core_data_o    (core_data),
        .core_modwait_i (core_modwait),
        .core_err_i     (core_err),
        .result_valid_o (result_valid),
        .err_pulse_o    (err_pulse),
        .timeout_flag_o (timeout_flag),
        .coeff_done_o   (coeff_done),
        .coeff_busy_o   (coeff_busy)
    );

    // Core model: after lc, or the second dr cycle, wait mw_delay cycles,
    // then hold modwait high for mw_busy cycles.
    int mw_delay = 1;
    int mw_busy  = 5;
    bit mw_never = 1'b0;
    int dly = 0;
    int bsy = 0;
    bit armed = 1'b0;
    bit dr_prev = 1'b0;

    always @(posedge clk) begin
        if (!n_rst) begin
            armed        <= 1'b0;
            core_modwait <= 1'b0;
            dr_prev      <= 1'b0;
        end else begin
            dr_prev <= core_dr;
            if (!mw_never && (core_lc || (core_dr && dr_prev))) begin
                dly   <= mw_delay;
                bsy   <= mw_busy;
                armed <= 1'b1;
            end else if (armed) begin
                if (dly > 0) begin
                    dly <= dly - 1;
                end else if (bsy > 0) begin
                    core_modwait <= 1'b1;
                    bsy <= bsy - 1;
                end else begin
                    core_modwait <= 1'b0;
                    armed <= 1'b0;
                end
            end
        end
    end

    // Event counters sampled mid-cycle.
    int n_res = 0, n_err = 0, n_done = 0, n_lc = 0, n_dr = 0;
    int dr_run = 0, last_dr_run = 0;

    always @(negedge clk) begin
        if (result_valid) n_res++;
        if (err_pulse)    n_err++;
        if (coeff_done)   n_done++;
        if (core_lc)      n_lc++;
        if (core_dr) begin
            n_dr++;
            dr_run++;
        end else if (dr_run != 0) begin
            last_dr_run = dr_run;
            dr_run = 0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_coeff(input logic [15:0] v);
        int n = 0;
        coeff_valid = 1'b1;
        coeff_in    = v;
        #1;
        while (!coeff_ready && n < 100) begin
            tick();
            n++;
        end
        check_eq("coeff_grant_wait", 32'(n < 100), 1);
        tick();
        coeff_valid = 1'b0;
        check_eq("lc_high", core_lc, 1);
        check_eq("lc_data", core_data, v);
    endtask

    task automatic send_sample(input logic [15:0] v);
        int n = 0;
        sample_valid = 1'b1;
        sample_in    = v;
        #1;
        while (!sample_ready && n < 100) begin
            tick();
            n++;
        end
        check_eq("sample_accept_wait", 32'(n < 100), 1);
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic wait_pulse(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!(result_valid || err_pulse || coeff_done) && cyc < 200);
        check_eq("pulse_wait", 32'(cyc < 200), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int cyc;
        int base, base2, bad;

        // Reset state.
        n_rst = 1'b0;
        repeat (3) tick();
        check_eq("rst_sample_ready", sample_ready, 1);
        check_eq("rst_coeff_ready", coeff_ready, 0);
        check_eq("rst_dr", core_dr, 0);
        check_eq("rst_lc", core_lc, 0);
        check_eq("rst_data", core_data, 0);
        check_eq("rst_pulses", {result_valid, err_pulse, coeff_done, timeout_flag, coeff_busy}, 0);
        n_rst = 1'b1;
        tick();

        // Four coefficient reload.
        mw_delay = 1;
        mw_busy  = 5;
        base  = n_lc;
        base2 = n_done;
        send_coeff(16'h0001);
        check_eq("cbusy_after_first", coeff_busy, 1);
        send_coeff(16'h0002);
        send_coeff(16'h0003);
        send_coeff(16'h0004);
        wait_pulse(cyc);
        check_eq("coeff_done_pulse", coeff_done, 1);
        check_eq("coeff_done_count", n_done - base2, 1);
        check_eq("lc_pulse_count", n_lc - base, 4);
        check_eq("cbusy_after_done", coeff_busy, 0);
        tick();
        check_eq("coeff_done_single", coeff_done, 0);

        // Single sample, long busy.
        mw_busy = 12;
        base = n_res;
        send_sample(16'h1234);
        check_eq("launch_ready_low", sample_ready, 0);
        tick();
        check_eq("dr1_high", core_dr, 1);
        check_eq("dr1_data", core_data, 16'h1234);
        check_eq("dr1_ready_back", sample_ready, 1);
        bad = 0;
        cyc = 0;
        do begin
            if (core_data !== 16'h1234) bad++;
            tick();
            cyc++;
        end while (!result_valid && cyc < 200);
        check_eq("sample_result_wait", 32'(cyc < 200), 1);
        check_eq("data_stable", bad, 0);
        check_eq("dr_run_len", last_dr_run, 2);
        check_eq("result_pulse", result_valid, 1);
        check_eq("no_err_pulse", err_pulse, 0);
        check_eq("result_count", n_res - base, 1);
        tick();
        check_eq("result_single", result_valid, 0);
        check_eq("ready_idle", sample_ready, 1);

        // Sample arrives mid reload set.
        mw_busy = 5;
        base = n_dr;
        send_coeff(16'h0011);
        send_coeff(16'h0022);
        send_sample(16'h5555);
        check_eq("mid_set_buffered", sample_ready, 0);
        send_coeff(16'h0033);
        send_coeff(16'h0044);
        wait_pulse(cyc);
        check_eq("mid_set_done", coeff_done, 1);
        check_eq("mid_set_no_dr", n_dr - base, 0);
        check_eq("mid_set_still_held", sample_ready, 0);
        tick();
        check_eq("mid_set_dr", core_dr, 1);
        check_eq("mid_set_data", core_data, 16'h5555);
        wait_pulse(cyc);
        check_eq("mid_set_result", result_valid, 1);

        // Buffered sample beats a waiting coefficient.
        send_sample(16'h0A0A);
        tick();
        send_sample(16'h0B0B);
        coeff_valid = 1'b1;
        coeff_in    = 16'h00C1;
        #1;
        check_eq("prio_busy_no_grant", coeff_ready, 0);
        wait_pulse(cyc);
        check_eq("prio_a_result", result_valid, 1);
        check_eq("prio_coeff_blocked", coeff_ready, 0);
        check_eq("prio_b_buffered", sample_ready, 0);
        tick();
        check_eq("prio_b_dr", core_dr, 1);
        check_eq("prio_b_data", core_data, 16'h0B0B);
        wait_pulse(cyc);
        check_eq("prio_b_result", result_valid, 1);
        check_eq("prio_coeff_grant", coeff_ready, 1);
        tick();
        coeff_valid = 1'b0;
        check_eq("prio_lc", core_lc, 1);
        check_eq("prio_lc_data", core_data, 16'h00C1);
        send_coeff(16'h00C2);
        send_coeff(16'h00C3);
        send_coeff(16'h00C4);
        wait_pulse(cyc);
        check_eq("prio_set_done", coeff_done, 1);

        // Watchdog timeout, then recovery.
        mw_never = 1'b1;
        send_sample(16'h0BAD);
        wait_pulse(cyc);
        check_eq("tmo_latency", cyc, 7);
        check_eq("tmo_err_pulse", err_pulse, 1);
        check_eq("tmo_no_result", result_valid, 0);
        check_eq("tmo_flag_set", timeout_flag, 1);
        tick();
        check_eq("tmo_flag_sticky", timeout_flag, 1);
        check_eq("tmo_err_single", err_pulse, 0);
        mw_never = 1'b0;
        send_sample(16'h600D);
        wait_pulse(cyc);
        check_eq("recover_result", result_valid, 1);
        check_eq("recover_flag_clr", timeout_flag, 0);

        // Core error at completion.
        core_err = 1'b1;
        send_sample(16'h0E0E);
        wait_pulse(cyc);
        check_eq("cerr_err_pulse", err_pulse, 1);
        check_eq("cerr_no_result", result_valid, 0);
        check_eq("cerr_no_tflag", timeout_flag, 0);
        core_err = 1'b0;
        tick();

        // Reset while waiting for completion.
        mw_busy = 12;
        send_sample(16'h7777);
        repeat (8) tick();
        check_eq("pre_rst_data", core_data, 16'h7777);
        base  = n_res;
        base2 = n_err;
        n_rst = 1'b0;
        tick();
        check_eq("mid_rst_data", core_data, 0);
        check_eq("mid_rst_ready", sample_ready, 1);
        check_eq("mid_rst_outs", {core_dr, core_lc, result_valid, err_pulse, coeff_done, timeout_flag, coeff_busy}, 0);
        n_rst = 1'b1;
        repeat (20) tick();
        check_eq("mid_rst_no_result", n_res - base, 0);
        check_eq("mid_rst_no_err", n_err - base2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
